// File: rtl/wb_arb_pkg.sv
// Shared constants and helpers for the two-master 8-bit Wishbone arbiter.
package wb_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_OWN0 = 2'b01;
  localparam logic [1:0] ST_OWN1 = 2'b10;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  localparam logic [7:0] WB_ERR_DATA = 8'hFF;

  // Saturating up/down count of strobes accepted by the slave but not yet acked.
  function automatic logic [1:0] outstanding_step(input logic [1:0] cur, input logic inc, input logic dec);
    logic [1:0] nxt;
    case ({inc, dec})
      2'b10:   nxt = (cur == 2'b11) ? cur : cur + 2'b01;
      2'b01:   nxt = (cur == 2'b00) ? cur : cur - 2'b01;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Bus watchdog: counts cycles without an ack and emits a one-cycle expiry pulse.
// Only present in builds that define WB_ARB_TIMEOUT_EN.
`ifdef WB_ARB_TIMEOUT_EN
module wb_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic reload,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // The pulse is registered, so it lands TIMEOUT_CYCLES cycles after the first stuck cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      expire <= 1'b0;
    end else if (reload || expire) begin
      count  <= '0;
      expire <= 1'b0;
    end else if (active) begin
      count  <= (count == LAST) ? '0 : count + CW'(1);
      expire <= (count == LAST);
    end else begin
      count  <= count;
      expire <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/wb8_master_arbiter.sv
// Two-master round-robin arbiter for the shared 8-bit pipelined Wishbone bus.
// Define WB_ARB_TIMEOUT_EN to add the bus watchdog and sticky O_err flag.
module wb8_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADRBITS        = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               I_wb_clk,
  input  logic               I_reset,
  input  logic               I_m0_cyc,
  input  logic               I_m0_stb,
  input  logic               I_m0_we,
  input  logic [ADRBITS-1:0] I_m0_adr,
  input  logic [7:0]         I_m0_dat,
  output logic [7:0]         O_m0_dat,
  output logic               O_m0_ack,
  output logic               O_m0_stall,
  input  logic               I_m1_cyc,
  input  logic               I_m1_stb,
  input  logic               I_m1_we,
  input  logic [ADRBITS-1:0] I_m1_adr,
  input  logic [7:0]         I_m1_dat,
  output logic [7:0]         O_m1_dat,
  output logic               O_m1_ack,
  output logic               O_m1_stall,
  output logic               O_s_cyc,
  output logic               O_s_stb,
  output logic               O_s_we,
  output logic [ADRBITS-1:0] O_s_adr,
  output logic [7:0]         O_s_dat,
  input  logic [7:0]         I_s_dat,
  input  logic               I_s_ack,
  input  logic               I_s_stall,
  output logic [1:0]         O_grant,
  output logic               O_err,
  input  logic               I_err_clr
);

  logic [1:0] state;
  logic [1:0] state_next;
  logic       last_owner;   // 1'b1 = M1 held the bus last
  logic       own0;
  logic       own1;
  logic       expire;

  assign own0 = (state == ST_OWN0);
  assign own1 = (state == ST_OWN1);

  // Ownership lasts a whole CYC; on a tie the master that did not own last wins.
  always_comb begin
    state_next = ST_IDLE;
    case (state)
      ST_IDLE: begin
        if (I_m0_cyc && I_m1_cyc) state_next = last_owner ? ST_OWN0 : ST_OWN1;
        else if (I_m0_cyc)        state_next = ST_OWN0;
        else if (I_m1_cyc)        state_next = ST_OWN1;
        else                      state_next = ST_IDLE;
      end
      ST_OWN0: begin
        if (I_m0_cyc)      state_next = ST_OWN0;
        else if (I_m1_cyc) state_next = ST_OWN1;
        else               state_next = ST_IDLE;
      end
      ST_OWN1: begin
        if (I_m1_cyc)      state_next = ST_OWN1;
        else if (I_m0_cyc) state_next = ST_OWN0;
        else               state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Owner state and round-robin memory.
  always_ff @(posedge I_wb_clk or posedge I_reset) begin
    if (I_reset) begin
      state      <= ST_IDLE;
      last_owner <= 1'b1;
    end else begin
      state <= state_next;
      if (state_next == ST_OWN0)      last_owner <= 1'b0;
      else if (state_next == ST_OWN1) last_owner <= 1'b1;
      else                            last_owner <= last_owner;
    end
  end

  // Grant indication follows the owner register.
  always_comb begin
    case (state)
      ST_OWN0: O_grant = GRANT_M0;
      ST_OWN1: O_grant = GRANT_M1;
      default: O_grant = GRANT_NONE;
    endcase
  end

  // The decoder sees only the owner; a watchdog expiry suppresses the strobe.
  always_comb begin
    O_s_cyc = 1'b0;
    O_s_stb = 1'b0;
    O_s_we  = 1'b0;
    O_s_adr = '0;
    O_s_dat = 8'h00;
    if (own0) begin
      O_s_cyc = I_m0_cyc;
      O_s_stb = I_m0_stb && !expire;
      O_s_we  = I_m0_we;
      O_s_adr = I_m0_adr;
      O_s_dat = I_m0_dat;
    end else if (own1) begin
      O_s_cyc = I_m1_cyc;
      O_s_stb = I_m1_stb && !expire;
      O_s_we  = I_m1_we;
      O_s_adr = I_m1_adr;
      O_s_dat = I_m1_dat;
    end else begin
      O_s_cyc = 1'b0;
      O_s_stb = 1'b0;
    end
  end

  assign O_m0_ack   = own0 && (I_s_ack || expire);
  assign O_m0_dat   = own0 ? (expire ? WB_ERR_DATA : I_s_dat) : 8'h00;
  assign O_m0_stall = own0 ? I_s_stall : 1'b1;
  assign O_m1_ack   = own1 && (I_s_ack || expire);
  assign O_m1_dat   = own1 ? (expire ? WB_ERR_DATA : I_s_dat) : 8'h00;
  assign O_m1_stall = own1 ? I_s_stall : 1'b1;

`ifdef WB_ARB_TIMEOUT_EN
  logic [1:0] outstanding;
  logic       grant_change;
  logic       owner_stb;
  logic       owner_ack;
  logic       wd_active;

  assign grant_change = (state_next != state);
  assign owner_stb    = (own0 && I_m0_stb) || (own1 && I_m1_stb);
  assign owner_ack    = (own0 || own1) && I_s_ack;
  assign wd_active    = (owner_stb || (outstanding != 2'b00)) && !I_s_ack;

  // Outstanding transfers of the current owner; restarts with every new owner.
  always_ff @(posedge I_wb_clk or posedge I_reset) begin
    if (I_reset)                     outstanding <= 2'b00;
    else if (grant_change || expire) outstanding <= 2'b00;
    else outstanding <= outstanding_step(outstanding, O_s_stb && !I_s_stall, owner_ack);
  end

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (I_wb_clk),
    .rst   (I_reset),
    .active(wd_active),
    .reload(owner_ack || grant_change),
    .expire(expire)
  );

  // Sticky error flag; an expiry beats a clear in the same cycle.
  always_ff @(posedge I_wb_clk or posedge I_reset) begin
    if (I_reset)        O_err <= 1'b0;
    else if (expire)    O_err <= 1'b1;
    else if (I_err_clr) O_err <= 1'b0;
    else                O_err <= O_err;
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  logic unused_err_clr;

  assign unused_err_clr = I_err_clr;
  assign expire         = 1'b0;
  assign O_err          = 1'b0;
`endif

endmodule
